// File: rtl/gated_bus_reg.sv
// Registered shared-bus driver for N_SRC gated sources, with a bus keeper and
// gate-contention detection (sticky flag, first-offender capture, saturating count).
module gated_bus_reg #(
  parameter int WIDTH = 16,
  parameter int N_SRC = 4,
  parameter int CNT_W = 8
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic [N_SRC-1:0]         gate,
  input  logic [N_SRC*WIDTH-1:0]   src_data,
  input  logic                     err_clr,
  output logic [WIDTH-1:0]         bus_out,
  output logic                     bus_valid,
  output logic [$clog2(N_SRC)-1:0] bus_src,
  output logic                     contention,
  output logic                     err_sticky,
  output logic [N_SRC-1:0]         err_gate,
  output logic [CNT_W-1:0]         err_count
);

  localparam int SW = $clog2(N_SRC);
  localparam int PW = $clog2(N_SRC) + 1;

  logic [WIDTH-1:0] src_arr [N_SRC];
  logic [PW-1:0]    gate_cnt;
  logic [SW-1:0]    sel_idx;
  logic [WIDTH-1:0] sel_data;
  logic             is_one;
  logic             is_multi;

  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
      assign src_arr[gi] = src_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Index/data are only meaningful when exactly one gate is open.
  always_comb begin
    gate_cnt = '0;
    sel_idx  = '0;
    sel_data = '0;
    for (int i = 0; i < N_SRC; i++) begin
      gate_cnt = gate_cnt + PW'(gate[i]);
      if (gate[i]) begin
        sel_idx  = SW'(i);
        sel_data = src_arr[i];
      end
    end
    is_one   = (gate_cnt == PW'(1));
    is_multi = (gate_cnt > PW'(1));
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bus_out    <= '0;
      bus_valid  <= 1'b0;
      bus_src    <= '0;
      contention <= 1'b0;
    end else begin
      bus_valid  <= is_one;
      contention <= is_multi;
      if (is_one) begin
        bus_out <= sel_data;
        bus_src <= sel_idx;
      end
    end
  end

  // A clear in the same cycle as a contention event is applied before the event.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      err_sticky <= 1'b0;
      err_gate   <= '0;
      err_count  <= '0;
    end else if (err_clr) begin
      err_sticky <= is_multi;
      err_gate   <= is_multi ? gate : '0;
      err_count  <= is_multi ? CNT_W'(1) : '0;
    end else if (is_multi) begin
      err_sticky <= 1'b1;
      if (!err_sticky)
        err_gate <= gate;
      if (err_count != {CNT_W{1'b1}})
        err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_gated_bus_reg.sv
// Directed, table-driven bench for gated_bus_reg (WIDTH=16, N_SRC=4, CNT_W=8).
module tb_gated_bus_reg;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [3:0]  gate = '0;
  logic [63:0] src_data = '0;
  logic        err_clr = 1'b0;
  logic [15:0] bus_out;
  logic        bus_valid;
  logic [1:0]  bus_src;
  logic        contention;
  logic        err_sticky;
  logic [3:0]  err_gate;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  gated_bus_reg #(.WIDTH(16), .N_SRC(4), .CNT_W(8)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .gate(gate), .src_data(src_data), .err_clr(err_clr),
    .bus_out(bus_out), .bus_valid(bus_valid), .bus_src(bus_src), .contention(contention),
    .err_sticky(err_sticky), .err_gate(err_gate), .err_count(err_count)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0]  gate;
    logic [63:0] src;
    logic        clr;
    logic [15:0] e_bus;
    logic        e_valid;
    logic [1:0]  e_src;
    logic        e_cont;
    logic        e_sticky;
    logic [3:0]  e_egate;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] e_bus, input logic e_valid,
                           input logic [1:0] e_src, input logic e_cont, input logic e_sticky,
                           input logic [3:0] e_egate, input logic [7:0] e_cnt);
    check({tag, ".bus_out"},    32'(bus_out),    32'(e_bus));
    check({tag, ".bus_valid"},  32'(bus_valid),  32'(e_valid));
    check({tag, ".bus_src"},    32'(bus_src),    32'(e_src));
    check({tag, ".contention"}, 32'(contention), 32'(e_cont));
    check({tag, ".err_sticky"}, 32'(err_sticky), 32'(e_sticky));
    check({tag, ".err_gate"},   32'(err_gate),   32'(e_egate));
    check({tag, ".err_count"},  32'(err_count),  32'(e_cnt));
  endtask

  // Drive inputs, take one edge, sample 1 time unit after it.
  task automatic step(input logic [3:0] g, input logic [63:0] s, input logic c);
    gate = g; src_data = s; err_clr = c;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    // src_data = {src3, src2, src1, src0}
    vecs[0]  = '{4'b0100, {16'h3333, 16'hBEEF, 16'h1111, 16'h0000}, 1'b0, 16'hBEEF, 1'b1, 2'd2, 1'b0, 1'b0, 4'b0000, 8'd0};
    vecs[1]  = '{4'b0000, {16'h4444, 16'h2222, 16'h5555, 16'h6666}, 1'b0, 16'hBEEF, 1'b0, 2'd2, 1'b0, 1'b0, 4'b0000, 8'd0};
    vecs[2]  = '{4'b0000, {16'h7777, 16'h8888, 16'h9999, 16'hAAAA}, 1'b0, 16'hBEEF, 1'b0, 2'd2, 1'b0, 1'b0, 4'b0000, 8'd0};
    vecs[3]  = '{4'b0000, {16'hBBBB, 16'hCCCC, 16'hDDDD, 16'hEEEE}, 1'b0, 16'hBEEF, 1'b0, 2'd2, 1'b0, 1'b0, 4'b0000, 8'd0};
    vecs[4]  = '{4'b0110, {16'h0001, 16'h0002, 16'h0003, 16'h0004}, 1'b0, 16'hBEEF, 1'b0, 2'd2, 1'b1, 1'b1, 4'b0110, 8'd1};
    vecs[5]  = '{4'b1001, {16'h0005, 16'h0006, 16'h0007, 16'h0008}, 1'b0, 16'hBEEF, 1'b0, 2'd2, 1'b1, 1'b1, 4'b0110, 8'd2};
    vecs[6]  = '{4'b1000, {16'hCAFE, 16'h0006, 16'h0007, 16'h0008}, 1'b0, 16'hCAFE, 1'b1, 2'd3, 1'b0, 1'b1, 4'b0110, 8'd2};
    vecs[7]  = '{4'b1100, {16'h1010, 16'h2020, 16'h3030, 16'h4040}, 1'b1, 16'hCAFE, 1'b0, 2'd3, 1'b1, 1'b1, 4'b1100, 8'd1};
    vecs[8]  = '{4'b0001, {16'h1010, 16'h2020, 16'h3030, 16'h5A5A}, 1'b1, 16'h5A5A, 1'b1, 2'd0, 1'b0, 1'b0, 4'b0000, 8'd0};
    vecs[9]  = '{4'b0010, {16'h1010, 16'h2020, 16'h0F0F, 16'h5A5A}, 1'b0, 16'h0F0F, 1'b1, 2'd1, 1'b0, 1'b0, 4'b0000, 8'd0};
    vecs[10] = '{4'b1111, {16'hFFFF, 16'hEEEE, 16'hDDDD, 16'hCCCC}, 1'b0, 16'h0F0F, 1'b0, 2'd1, 1'b1, 1'b1, 4'b1111, 8'd1};
    vecs[11] = '{4'b0000, {16'hFFFF, 16'hEEEE, 16'hDDDD, 16'hCCCC}, 1'b0, 16'h0F0F, 1'b0, 2'd1, 1'b0, 1'b1, 4'b1111, 8'd1};
    vecs[12] = '{4'b0000, {16'hFFFF, 16'hEEEE, 16'hDDDD, 16'hCCCC}, 1'b1, 16'h0F0F, 1'b0, 2'd1, 1'b0, 1'b0, 4'b0000, 8'd0};

    // Power-up reset, then load state so the async reset has something to clear.
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    step(4'b0011, 64'h0, 1'b0);
    step(4'b0001, {48'h0, 16'h1234}, 1'b0);
    check_all("preload", 16'h1234, 1'b1, 2'd0, 1'b0, 1'b1, 4'b0011, 8'd1);
    $display("preload: bus_out=%h err_count=%0d", bus_out, err_count);

    // Asynchronous reset mid-cycle, no clock edge in between.
    gate = 4'b0000;
    #2;
    Reset_n = 1'b0;
    #1;
    check_all("async_rst", 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 8'd0);
    $display("async_rst: bus_out=%h err_sticky=%b", bus_out, err_sticky);
    #1;
    Reset_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      step(vecs[i].gate, vecs[i].src, vecs[i].clr);
      check_all($sformatf("vec%0d", i), vecs[i].e_bus, vecs[i].e_valid, vecs[i].e_src,
                vecs[i].e_cont, vecs[i].e_sticky, vecs[i].e_egate, vecs[i].e_cnt);
      $display("vec%0d: gate=%b clr=%b bus_out=%h valid=%b src=%0d cont=%b sticky=%b egate=%b cnt=%0d",
               i, vecs[i].gate, vecs[i].clr, bus_out, bus_valid, bus_src, contention,
               err_sticky, err_gate, err_count);
    end

    // Saturation: 300 back-to-back contention cycles from a cleared counter.
    for (int n = 1; n <= 300; n++) begin
      step(4'b0011, {48'h0, 16'h9999}, 1'b0);
      if (n == 254 || n == 255 || n == 300) begin
        check_all($sformatf("sat%0d", n), 16'h0F0F, 1'b0, 2'd1, 1'b1, 1'b1, 4'b0011,
                  (n == 254) ? 8'hFE : 8'hFF);
        $display("sat%0d: err_count=%h contention=%b", n, err_count, contention);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
